// File: rtl/button_event_detector.sv
// Turns a debounced button level into single-cycle press, release, click,
// double-click and long-press pulses using one timed FSM and a shared counter.
module button_event_detector #(
  parameter int LONG_CYCLES = 16,
  parameter int GAP_CYCLES  = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_click,
  output logic double_click,
  output logic long_press,
  output logic held
);

  localparam int MAX_CYCLES = (LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRESSED,
    LONG_HELD,
    WAIT_GAP,
    SECOND_PRESSED
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_inc;
  logic             prev_level;
  logic             rise;
  logic             fall;

  assign rise      = btn_level & ~prev_level;
  assign fall      = ~btn_level & prev_level;
  assign count_inc = (count == {CNT_W{1'b1}}) ? count : count + CNT_W'(1);

  // Edge checks come before the timers in every state, so a release at the
  // long threshold stays a short press and a re-press at the gap timeout
  // still counts as the second press.
  always_ff @(posedge clock) begin
    if (reset) begin
      prev_level    <= 1'b0;
      state         <= IDLE;
      count         <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_click   <= 1'b0;
      double_click  <= 1'b0;
      long_press    <= 1'b0;
      held          <= 1'b0;
    end else begin
      prev_level    <= btn_level;
      press_pulse   <= rise;
      release_pulse <= fall;
      short_click   <= 1'b0;
      double_click  <= 1'b0;
      long_press    <= 1'b0;

      case (state)
        IDLE: begin
          count <= '0;
          if (rise) begin
            state <= PRESSED;
            held  <= 1'b1;
          end else begin
            held  <= 1'b0;
          end
        end

        PRESSED: begin
          if (fall) begin
            state <= WAIT_GAP;
            count <= '0;
            held  <= 1'b0;
          end else if (count == LONG_LAST) begin
            state      <= LONG_HELD;
            count      <= '0;
            long_press <= 1'b1;
            held       <= 1'b1;
          end else begin
            count <= count_inc;
            held  <= 1'b1;
          end
        end

        LONG_HELD: begin
          if (fall) begin
            state <= IDLE;
            count <= '0;
            held  <= 1'b0;
          end else begin
            count <= count_inc;
            held  <= 1'b1;
          end
        end

        WAIT_GAP: begin
          if (rise) begin
            state <= SECOND_PRESSED;
            count <= '0;
            held  <= 1'b1;
          end else if (count == GAP_LAST) begin
            state       <= IDLE;
            count       <= '0;
            short_click <= 1'b1;
            held        <= 1'b0;
          end else begin
            count <= count_inc;
            held  <= 1'b0;
          end
        end

        SECOND_PRESSED: begin
          if (fall) begin
            state        <= IDLE;
            count        <= '0;
            double_click <= 1'b1;
            held         <= 1'b0;
          end else if (count == LONG_LAST) begin
            state      <= LONG_HELD;
            count      <= '0;
            long_press <= 1'b1;
            held       <= 1'b1;
          end else begin
            count <= count_inc;
            held  <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          count <= '0;
          held  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_event_detector.sv
// Directed scoreboard bench: each step queues the pulses it should cause at
// absolute cycle numbers, and every cycle the DUT pulses are checked against the queue.
module tb_button_event_detector;

  localparam int LONG = 8;
  localparam int GAP  = 6;

  localparam logic [4:0] EV_PRESS   = 5'b00001;
  localparam logic [4:0] EV_RELEASE = 5'b00010;
  localparam logic [4:0] EV_SHORT   = 5'b00100;
  localparam logic [4:0] EV_DOUBLE  = 5'b01000;
  localparam logic [4:0] EV_LONG    = 5'b10000;

  typedef struct {
    int         cyc;
    logic [4:0] ev;
  } exp_t;

  logic clock;
  logic reset;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic short_click;
  logic double_click;
  logic long_press;
  logic held;

  exp_t exp_q[$];
  int   cyc;
  int   test_count;
  int   fail_count;
  int   press_cyc;
  int   release_cyc;
  logic tb_prev;

  button_event_detector #(
    .LONG_CYCLES(LONG),
    .GAP_CYCLES (GAP)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .short_click  (short_click),
    .double_click (double_click),
    .long_press   (long_press),
    .held         (held)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic pushExp(input int c, input logic [4:0] ev);
    exp_t e;
    e.cyc = c;
    e.ev  = ev;
    exp_q.push_back(e);
  endtask

  // Drives a new level; edge pulses are queued for the edge that samples it.
  task automatic applyStimulus(input logic lvl);
    btn_level = lvl;
    if (lvl && !tb_prev) begin
      press_cyc = cyc + 1;
      pushExp(press_cyc, EV_PRESS);
    end
    if (!lvl && tb_prev) begin
      release_cyc = cyc + 1;
      pushExp(release_cyc, EV_RELEASE);
    end
    tb_prev = lvl;
  endtask

  task automatic checkOutput();
    logic [4:0] expv;
    logic [4:0] obs;
    expv = '0;
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc == cyc) begin
        expv = expv | exp_q[i].ev;
        exp_q.delete(i);
      end
    end
    obs = {long_press, double_click, short_click, release_pulse, press_pulse};
    test_count++;
    assert (obs === expv) else begin
      fail_count++;
      $error("[TB] FAIL pulses cyc=%0d observed=%b expected=%b", cyc, obs, expv);
    end
  endtask

  task automatic checkHeld(input logic expected, input string tag);
    test_count++;
    assert (held === expected) else begin
      fail_count++;
      $error("[TB] FAIL held_%s cyc=%0d observed=%b expected=%b", tag, cyc, held, expected);
    end
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      checkOutput();
    end
  endtask

  initial begin
    test_count = 0;
    fail_count = 0;
    tb_prev    = 1'b0;
    reset      = 1'b1;
    btn_level  = 1'b0;

    // Reset state
    runCycles(2);
    checkHeld(1'b0, "reset");
    reset = 1'b0;
    runCycles(3);

    // Short click: high 3 cycles, then low
    applyStimulus(1'b1);
    runCycles(1);
    checkHeld(1'b1, "short_press");
    runCycles(2);
    applyStimulus(1'b0);
    pushExp(release_cyc + GAP, EV_SHORT);
    runCycles(1);
    checkHeld(1'b0, "short_release");
    runCycles(10);

    // Long press: high 20 cycles
    applyStimulus(1'b1);
    pushExp(press_cyc + LONG, EV_LONG);
    for (int i = 0; i < 20; i++) begin
      runCycles(1);
      checkHeld(1'b1, "long");
    end
    applyStimulus(1'b0);
    runCycles(1);
    checkHeld(1'b0, "long_release");
    runCycles(12);

    // Double click: high 2, low 3, high 2, low
    applyStimulus(1'b1);
    runCycles(2);
    applyStimulus(1'b0);
    runCycles(3);
    applyStimulus(1'b1);
    runCycles(2);
    applyStimulus(1'b0);
    pushExp(release_cyc, EV_DOUBLE);
    runCycles(12);

    // Release exactly at the long threshold edge
    applyStimulus(1'b1);
    runCycles(LONG);
    applyStimulus(1'b0);
    pushExp(release_cyc + GAP, EV_SHORT);
    runCycles(12);

    // Second press exactly at the gap timeout edge
    applyStimulus(1'b1);
    runCycles(2);
    applyStimulus(1'b0);
    runCycles(GAP);
    applyStimulus(1'b1);
    runCycles(1);
    checkHeld(1'b1, "gap_race");
    runCycles(1);
    applyStimulus(1'b0);
    pushExp(release_cyc, EV_DOUBLE);
    runCycles(12);

    // Second press held long
    applyStimulus(1'b1);
    runCycles(2);
    applyStimulus(1'b0);
    runCycles(3);
    applyStimulus(1'b1);
    pushExp(press_cyc + LONG, EV_LONG);
    runCycles(12);
    checkHeld(1'b1, "second_long");
    applyStimulus(1'b0);
    runCycles(12);

    // Reset mid-press with the button still high
    applyStimulus(1'b1);
    runCycles(6);
    reset = 1'b1;
    runCycles(1);
    checkHeld(1'b0, "mid_reset");
    reset   = 1'b0;
    tb_prev = 1'b0;
    applyStimulus(1'b1);
    pushExp(press_cyc + LONG, EV_LONG);
    runCycles(1);
    checkHeld(1'b1, "after_reset");
    runCycles(11);
    applyStimulus(1'b0);
    runCycles(10);

    test_count++;
    assert (exp_q.size() === 0) else begin
      fail_count++;
      $error("[TB] FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule

// File: doc/button_event_detector.md
Name: button_event_detector

Overview:
Consumes the clean, clock-synchronous level from the input debouncer and turns it into single-cycle event pulses: press, release, short click, double click and long press. It sits directly downstream of the debouncer, between the debounced button line and the control/UI logic. It is a timed FSM with one shared cycle counter.

Parameters:
LONG_CYCLES, 16, cycles the button must stay pressed before long_press fires; must be >= 2.
GAP_CYCLES, 8, maximum cycles between first release and second press for a double click; must be >= 2.
CNT_W, $clog2(max(LONG_CYCLES,GAP_CYCLES)+1), counter width; derived, never overridden.

Ports:
clock  input  1  single system clock, rising edge.
reset  input  1  synchronous, active-high reset.
btn_level  input  1  debounced level, synchronous to clock, 1 = pressed.
press_pulse  output  1  one-cycle pulse per debounced rising edge.
release_pulse  output  1  one-cycle pulse per debounced falling edge.
short_click  output  1  one-cycle pulse: single short press confirmed.
double_click  output  1  one-cycle pulse: two short presses within GAP_CYCLES.
long_press  output  1  one-cycle pulse: press held LONG_CYCLES.
held  output  1  registered, 1 while FSM is in any pressed state.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. Reset sets prev_level=0, state=IDLE, count=0 and every output to 0 on the next rising edge. Reset overrides all other activity, including mid-press.
- Edge detection: prev_level registers btn_level. rise = btn_level & ~prev_level. fall = ~btn_level & prev_level.
- All outputs are registered. A pulse is high for exactly one cycle, in the cycle after the edge at which its condition is evaluated.
- press_pulse and release_pulse follow every rise/fall in all states, independent of the FSM.
- States: IDLE, PRESSED, LONG_HELD, WAIT_GAP, SECOND_PRESSED. Any entry into a timed state clears count to 0. In a timed state with no transition, count increments by 1 and never wraps.
- IDLE: rise -> PRESSED.
- PRESSED:
  - fall -> WAIT_GAP.
  - Otherwise, when count==LONG_CYCLES-1 -> LONG_HELD, and long_press is asserted. long_press is therefore high exactly LONG_CYCLES cycles after press_pulse.
- LONG_HELD: fall -> IDLE with no click event. long_press fires only once per press.
- WAIT_GAP:
  - rise -> SECOND_PRESSED.
  - Otherwise, when count==GAP_CYCLES-1 -> IDLE, and short_click is asserted. short_click is therefore high exactly GAP_CYCLES cycles after release_pulse.
- SECOND_PRESSED:
  - fall -> IDLE, and double_click is asserted (same cycle as release_pulse).
  - Otherwise, when count==LONG_CYCLES-1 -> LONG_HELD, and long_press is asserted. No double_click or short_click is reported for that sequence.
- held = 1 when the next state is PRESSED, LONG_HELD or SECOND_PRESSED.
- Simultaneous events:
  - A fall at the same edge as the long threshold wins: treated as a short release, no long_press.
  - A rise at the same edge as the gap timeout wins: becomes SECOND_PRESSED, no short_click.
- At most one of short_click, double_click and long_press is high in any cycle.
- btn_level high when reset deasserts: prev_level=0, so the first edge detects a rise and produces a normal press_pulse and PRESSED entry.

Test Plan:
- Short click (LONG=8, GAP=6). Reset, then btn_level high 3 cycles, then low. Required: press_pulse once, release_pulse once, short_click exactly 6 cycles after release_pulse, no other events.
- Long press. btn_level high 20 cycles. Required: long_press exactly 8 cycles after press_pulse, one cycle only. held=1 for the whole press. On release: release_pulse only, no click.
- Double click. High 2 cycles, low 3, high 2, low. Required: two press_pulses, double_click coincident with the second release_pulse, no short_click, even after waiting 10 further cycles.
- Threshold race. Release at the exact edge where count==LONG_CYCLES-1. Required: no long_press; short_click 6 cycles later. Second race: a second press at the exact gap-timeout edge gives SECOND_PRESSED and no short_click.
- Second press held long. Click, then re-press within the gap and hold 12 cycles. Required: long_press 8 cycles after the second press_pulse, no double_click, no short_click.
- Reset mid-operation. Assert reset for 1 cycle while in PRESSED with count=5 and btn_level held high. Required: all outputs 0 the next cycle. The following cycle gives press_pulse=1 and a fresh PRESSED with count=0. long_press comes 8 cycles after that press_pulse.
